// File: rtl/fetch_unit.sv
// Instruction-fetch stage.
//
// Drives nextPc for an external pc_register. That register loads nextPc on every clock edge
// and has no enable and no reset. The block fetches the word at Pc over a req/ready handshake
// and queues {instr, pc} in a 2-entry FIFO for decode. It also handles branch redirect with
// FIFO flush, dropping of a response that is already in flight, and memory timeout.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   Pc / nextPc     current PC in, PC to load at the next edge out
//   imem_*          fetch request / address, response strobe / data
//   instr_*         decode-side valid/ready FIFO head: instruction word and its PC
//   branch_*        redirect strobe and target from execute
//   align_err       pulse in the cycle of a redirect to a misaligned target
//   bus_err         sticky fetch-timeout flag, cleared only by rst
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Pc,
  output logic [31:0] nextPc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        align_err,
  output logic        bus_err
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StBoot, StIdle, StWait, StDrop, StErr} state_e;

  state_e          state_q, state_d;
  logic [1:0]      count_q, count_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic [TmoW-1:0] tmo_q, tmo_d, tmo_inc;
  logic [31:0]     drop_addr_q, drop_addr_d;
  logic            bus_err_q, bus_err_d;
  logic [31:0]     fifo_instr_q [2];
  logic [31:0]     fifo_pc_q    [2];

  logic       branch;
  logic       push;
  logic       pop;
  logic [1:0] count_nf;

  // Redirects are only honoured while the PC is under our control.
  assign branch = branch_taken &&
                  ((state_q == StIdle) || (state_q == StWait) || (state_q == StDrop));
  assign pop    = instr_valid && instr_ready;
  assign push   = (state_q == StWait) && imem_ready && !branch;
  // Occupancy after this cycle's push/pop, ignoring flush; WAIT never starts at 2,
  // so this cannot overflow.
  assign count_nf = count_q + {1'b0, push} - {1'b0, pop};
  assign tmo_inc  = tmo_q + TmoW'(1);

  always_comb begin
    state_d     = state_q;
    tmo_d       = '0;
    drop_addr_d = drop_addr_q;
    bus_err_d   = bus_err_q;
    nextPc      = Pc;

    unique case (state_q)
      StBoot: begin
        nextPc  = RESET_PC;
        state_d = StIdle;
      end
      StIdle: begin
        if (!branch && (count_nf < 2'd2)) state_d = StWait;
      end
      StWait: begin
        if (branch) begin
          if (imem_ready) begin
            state_d = StIdle;
          end else begin
            // Response still owed by memory: remember where it was aimed.
            state_d     = StDrop;
            drop_addr_d = Pc;
          end
        end else if (imem_ready) begin
          nextPc = Pc + 32'd4;
          if (count_nf >= 2'd2) state_d = StIdle;
        end else if (tmo_inc == TmoW'(TIMEOUT)) begin
          state_d   = StErr;
          bus_err_d = 1'b1;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      StDrop: begin
        // A redirect here restarts the wait window and keeps waiting for the stale response.
        if (!branch) begin
          if (imem_ready) begin
            state_d = StIdle;
          end else if (tmo_inc == TmoW'(TIMEOUT)) begin
            state_d   = StErr;
            bus_err_d = 1'b1;
          end else begin
            tmo_d = tmo_inc;
          end
        end
      end
      StErr: begin
        state_d = StErr;
      end
      default: begin
        state_d = StBoot;
      end
    endcase

    if (branch) nextPc = {branch_target[31:2], 2'b00};
    if (rst)    nextPc = RESET_PC;
  end

  always_comb begin
    count_d  = count_nf;
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    // Flush wins over any same-cycle pop.
    if (branch) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StBoot;
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      tmo_q       <= '0;
      drop_addr_q <= 32'd0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      tmo_q       <= tmo_d;
      drop_addr_q <= drop_addr_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]    <= Pc;
    end
  end

  assign imem_req    = (state_q == StWait) || (state_q == StDrop);
  assign imem_addr   = (state_q == StDrop) ? drop_addr_q : Pc;
  assign instr_valid = (count_q != 2'd0);
  assign instr       = fifo_instr_q[rd_ptr_q];
  assign instr_pc    = fifo_pc_q[rd_ptr_q];
  assign align_err   = branch && (branch_target[1:0] != 2'b00);
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: pc_register model, memory responder and a transaction-level reference
// (request flags plus a queue of {instr, pc}) compared against the DUT every cycle.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned TIMEOUT  = 16;

  // Memory response modes
  localparam int ZeroWait = 0;
  localparam int OneWait  = 1;
  localparam int NoResp   = 2;
  localparam int RandResp = 3;
  localparam int SlowResp = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] Pc = 32'd0;
  logic [31:0] nextPc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        align_err;
  logic        bus_err;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  bit          m_boot = 1'b1;
  bit          m_fetch = 1'b0;
  bit          m_stale = 1'b0;
  bit          m_dead = 1'b0;
  int          m_tmo = 0;
  int          m_age = 0;
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_stale_addr = 32'd0;
  logic [63:0] m_q[$];

  fetch_unit #(
    .RESET_PC(RESET_PC),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .Pc           (Pc),
    .nextPc       (nextPc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .align_err    (align_err),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  // pc_register: loads every edge, no enable, no reset.
  always @(posedge clk) Pc <= nextPc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check outputs at negedge, advance the reference.
  task automatic cycle(input bit r, input bit br, input logic [31:0] bt, input int mode,
                       input bit ir);
    bit          mreq, rdy, brx, pop, exp_valid;
    logic [31:0] maddr, enpc;
    logic [63:0] head;
    mreq  = !r && (m_fetch || m_stale);
    maddr = m_fetch ? m_pc : m_stale_addr;
    case (mode)
      ZeroWait: rdy = mreq;
      OneWait:  rdy = mreq && (m_age >= 1);
      NoResp:   rdy = 1'b0;
      RandResp: rdy = mreq && ($urandom_range(0, 3) != 0);
      default:  rdy = mreq && ($urandom_range(0, 19) == 0);
    endcase
    rst           = r;
    branch_taken  = br;
    branch_target = bt;
    imem_ready    = rdy;
    imem_rdata    = mem_word(maddr);
    instr_ready   = ir;

    @(negedge clk);
    brx       = !r && br && !m_boot && !m_dead;
    exp_valid = !r && (m_q.size() != 0);
    pop       = exp_valid && ir;
    if (r || m_boot)       enpc = RESET_PC;
    else if (brx)          enpc = {bt[31:2], 2'b00};
    else if (m_fetch && rdy) enpc = m_pc + 32'd4;
    else                   enpc = m_pc;

    check_eq("nextPc", nextPc, enpc);
    check_eq("imem_req", 32'(imem_req), 32'(mreq));
    if (mreq) check_eq("imem_addr", imem_addr, maddr);
    check_eq("instr_valid", 32'(instr_valid), 32'(exp_valid));
    if (exp_valid) begin
      head = m_q[0];
      check_eq("instr", instr, head[63:32]);
      check_eq("instr_pc", instr_pc, head[31:0]);
    end
    check_eq("align_err", 32'(align_err), 32'(brx && (bt[1:0] != 2'b00)));
    check_eq("bus_err", 32'(bus_err), 32'(!r && m_dead));

    if (r) begin
      m_boot  = 1'b1;
      m_fetch = 1'b0;
      m_stale = 1'b0;
      m_dead  = 1'b0;
      m_tmo   = 0;
      m_age   = 0;
      m_q.delete();
      m_pc = RESET_PC;
    end else begin
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (brx) begin
        m_q.delete();
        m_tmo = 0;
        if (m_fetch) begin
          m_fetch = 1'b0;
          if (!rdy) begin
            m_stale      = 1'b1;
            m_stale_addr = m_pc;
          end
        end
      end else begin
        if (pop) void'(m_q.pop_front());
        if (m_fetch) begin
          if (rdy) begin
            m_q.push_back({mem_word(m_pc), m_pc});
            m_tmo = 0;
            if (m_q.size() >= 2) m_fetch = 1'b0;
          end else begin
            m_tmo++;
            if (m_tmo == int'(TIMEOUT)) begin
              m_fetch = 1'b0;
              m_dead  = 1'b1;
              m_tmo   = 0;
            end
          end
        end else if (m_stale) begin
          if (rdy) begin
            m_stale = 1'b0;
            m_tmo   = 0;
          end else begin
            m_tmo++;
            if (m_tmo == int'(TIMEOUT)) begin
              m_stale = 1'b0;
              m_dead  = 1'b1;
              m_tmo   = 0;
            end
          end
        end else if (!m_dead) begin
          if (m_q.size() < 2) m_fetch = 1'b1;
        end
      end
      m_age = (mreq && !rdy) ? m_age + 1 : 0;
      m_pc  = enpc;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 32'd0, ZeroWait, 1'b0);
    cycle(1'b1, 1'b0, 32'd0, ZeroWait, 1'b0);
  endtask

  task automatic run(input int n, input int mode, input bit ir);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, mode, ir);
  endtask

  // Redirect on the first cycle of a fresh request (response not yet returned in OneWait).
  task automatic branch_in_wait(input logic [31:0] tgt, input int mode);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (m_fetch && (m_age == 0)) begin
        cycle(1'b0, 1'b1, tgt, mode, 1'b1);
        done = 1'b1;
      end else begin
        cycle(1'b0, 1'b0, 32'd0, mode, 1'b1);
      end
    end
    check_eq("branch_issued", 32'(done), 32'd1);
  endtask

  initial begin
    bit seen;

    // Zero-wait memory, decode always ready: 1 instr/clk.
    do_reset();
    run(20, ZeroWait, 1'b1);

    // Decode stalled, 1-wait memory: exactly two words queued, Pc parked at 8.
    do_reset();
    run(12, OneWait, 1'b0);
    check_eq("stall_pc", Pc, 32'h8);
    check_eq("stall_req", 32'(imem_req), 32'd0);
    check_eq("stall_head_pc", instr_pc, 32'h0);
    run(12, OneWait, 1'b1);

    // Redirect while waiting: stale response dropped, next head is the target.
    branch_in_wait(32'h100, OneWait);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1'b0, 1'b0, 32'd0, OneWait, 1'b0);
      if (m_q.size() != 0) seen = 1'b1;
    end
    check_eq("redirect_seen", 32'(seen), 32'd1);
    check_eq("redirect_head_pc", instr_pc, 32'h100);
    run(6, OneWait, 1'b1);

    // Misaligned target: align_err pulse and fetch from the aligned address.
    branch_in_wait(32'h103, ZeroWait);
    run(8, ZeroWait, 1'b1);

    // Memory never answers: timeout to bus error with Pc frozen.
    do_reset();
    run(25, NoResp, 1'b1);
    check_eq("tmo_bus_err", 32'(bus_err), 32'd1);
    check_eq("tmo_req", 32'(imem_req), 32'd0);
    check_eq("tmo_pc", Pc, RESET_PC);
    do_reset();
    check_eq("tmo_cleared", 32'(bus_err), 32'd0);

    // Wrap-around at the top of the address space.
    do_reset();
    cycle(1'b0, 1'b0, 32'd0, ZeroWait, 1'b1);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, ZeroWait, 1'b1);
    run(10, ZeroWait, 1'b1);

    // Randomized segments.
    for (int s = 0; s < 10; s++) begin
      int mode;
      mode = (s % 5 == 4) ? SlowResp : int'($urandom_range(0, 1)) * 3 + int'($urandom_range(0, 1));
      if (mode == NoResp) mode = OneWait;
      do_reset();
      for (int i = 0; i < 200; i++) begin
        cycle($urandom_range(0, 199) == 0, $urandom_range(0, 14) == 0, $urandom, mode,
              $urandom_range(0, 3) != 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
